// File: rtl/counter_pkg.sv
// Shared types and defaults for the Lab 1 counter family (countdown_timer and friends).
package counter_pkg;

   typedef enum logic {IDLE, RUN} cd_state_t;

   localparam int CD_WIDTH_DEFAULT      = 8;
   localparam int CD_PRESCALE_W_DEFAULT = 16;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Programmable prescaler for countdown_timer: emits one tick every tick_div+1 enabled cycles.
module tick_prescaler #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  run,
   input  logic [PRESCALE_W-1:0] tick_div,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pre;

   // >= rather than == so that lowering tick_div mid-period ticks at once and pre never wraps.
   assign tick = run && (pre >= tick_div);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
      end else if (clr) begin
         pre <= '0;
      end else if (run) begin
         if (tick) begin
            pre <= '0;
         end else begin
            pre <= pre + PRESCALE_W'(1);
         end
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled decrements and a registered one-cycle done pulse.
// Optional periodic mode: define COUNTDOWN_AUTO_RELOAD_EN to reload v on expiry.
module countdown_timer
   import counter_pkg::*;
#(
   parameter int WIDTH      = CD_WIDTH_DEFAULT,
   parameter int PRESCALE_W = CD_PRESCALE_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld,
   input  logic [WIDTH-1:0]      v,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] tick_div,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  done,
   output cd_state_t             dbg_state
);

   cd_state_t        state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic             tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         reload_q <= '0;
      end else if (ld) begin
         reload_q <= v;
      end
   end
`endif

   tick_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .clr      (ld),
      .run      ((state_q == RUN) && en),
      .tick     (tick),
      .tick_div (tick_div)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   // ld wins over a same-cycle tick; tick already implies RUN and en.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
      if (ld) begin
         count_d = v;
         if (v != '0) begin
            state_d = RUN;
         end else begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end else if (tick) begin
         if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
         end else begin
            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (reload_q != '0) begin
               count_d = reload_q;
               state_d = RUN;
            end else begin
               count_d = '0;
               state_d = IDLE;
            end
`else
            count_d = '0;
            state_d = IDLE;
`endif
         end
      end
   end

   assign count     = count_q;
   assign busy      = (state_q == RUN);
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule
